// File: rtl/hc165_reader.sv
// Free-running scanner for a daisy chain of 74HC165 PISO registers.
// Loads the chain, shifts WIDTH bits, publishes the word with valid/changed strobes, idles, repeats.
module hc165_reader #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CLK_DIV  = 25,
  parameter int unsigned SCAN_GAP = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q7,
  output logic             pl_n,
  output logic             cp,
  output logic             ce_n,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             changed
);

  // One counter serves every phase; it must hold the longest terminal value.
  localparam int unsigned CNT_MAX = (2 * CLK_DIV > SCAN_GAP) ? 2 * CLK_DIV : SCAN_GAP;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W   = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HIGH_BEG = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(SCAN_GAP - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_START,
    ST_LOAD,
    ST_SETTLE,
    ST_SHIFT,
    ST_DONE,
    ST_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [BIT_W-1:0] bit_idx, bit_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             pl_n_nxt, cp_nxt, ce_n_nxt, valid_nxt, changed_nxt;
  logic             q7_meta, q7_sync;

  // Two-flop synchronizer for the asynchronous serial input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q7_meta <= 1'b1;
      q7_sync <= 1'b1;
    end else begin
      q7_meta <= q7;
      q7_sync <= q7_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_START;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data    <= '1;
      pl_n    <= 1'b1;
      cp      <= 1'b0;
      ce_n    <= 1'b1;
      valid   <= 1'b0;
      changed <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
      data    <= data_nxt;
      pl_n    <= pl_n_nxt;
      cp      <= cp_nxt;
      ce_n    <= ce_n_nxt;
      valid   <= valid_nxt;
      changed <= changed_nxt;
    end
  end

  // cnt counts cycles already spent in the current phase; outputs follow the next state
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    bit_nxt     = bit_idx;
    shreg_nxt   = shreg;
    data_nxt    = data;
    valid_nxt   = 1'b0;
    changed_nxt = 1'b0;

    case (state)
      ST_START: begin
        state_nxt = ST_LOAD;
        cnt_nxt   = '0;
      end
      ST_LOAD: begin
        if (cnt == HALF_END) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt == HALF_END) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = '0;
          bit_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        // Sample just before cp rises, while the chain output is settled
        if (cnt == HALF_END) begin
          shreg_nxt = {shreg[WIDTH-2:0], q7_sync};
        end
        if (cnt == BIT_END) begin
          cnt_nxt = '0;
          if (bit_idx == LAST_BIT) begin
            state_nxt   = ST_DONE;
            data_nxt    = shreg;
            valid_nxt   = 1'b1;
            changed_nxt = (shreg != data);
          end else begin
            bit_nxt = bit_idx + BIT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      ST_IDLE: begin
        if (cnt == GAP_END) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_START;
        cnt_nxt   = '0;
      end
    endcase

    pl_n_nxt = (state_nxt != ST_LOAD);
    ce_n_nxt = !((state_nxt == ST_SETTLE) || (state_nxt == ST_SHIFT));
    cp_nxt   = (state_nxt == ST_SHIFT) && (cnt_nxt >= HIGH_BEG);
  end

endmodule

// File: doc/hc165_reader.md
# hc165_reader

- Serial input scanner for a daisy-chain of 74HC165 parallel-in/serial-out shift registers that carry the board's switches and keys.
- Free-running loop: parallel-load the chain, shift out WIDTH bits, publish a registered parallel word with a one-cycle `valid` strobe, wait a configurable gap, repeat.
- Sits beside the 74HC595 display path; feeds the key filters and counters upstream of the display logic.

## Interface
- `WIDTH`, 16: bits in the chain; multiple of 8, 8..32.
- `CLK_DIV`, 25: system clocks per half period of `cp`; ≥ 2.
- `SCAN_GAP`, 50000: idle clocks between scans (1 ms at 50 MHz); ≥ 1.

- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `q7` input 1: serial data from QH of the last 165 in the chain.
- `pl_n` output 1: parallel load to the 165s, active low.
- `cp` output 1: shift clock to the 165s; each rising edge shifts the chain.
- `ce_n` output 1: clock-inhibit to the 165s; low enables shifting.
- `data` output WIDTH: last completed scan; the first bit received lands in `data[WIDTH-1]`.
- `valid` output 1: one-cycle pulse when `data` updates.
- `changed` output 1: one-cycle pulse coincident with `valid` when the new word differs from the previous `data`.

## Operation
- All outputs are registered.
- Reset values:
  - `pl_n`=1, `cp`=0, `ce_n`=1
  - `data`={WIDTH{1'b1}} (keys idle-high)
  - `valid`=0, `changed`=0
  - state=LOAD pending, all counters 0
- Input sync: `q7` passes through a 2-flop synchronizer; only the synchronized value is sampled.
- FSM: LOAD → SETTLE → SHIFT → DONE → IDLE → LOAD.
  - LOAD: `pl_n`=0 for CLK_DIV cycles; `cp`=0, `ce_n`=1.
  - SETTLE: `pl_n`=1 for CLK_DIV cycles; `ce_n` drops to 0 on entry.
  - SHIFT: WIDTH bit periods of 2*CLK_DIV cycles each.
    - Low phase: `cp`=0 for CLK_DIV cycles. On the last cycle of the low phase, shift the synchronized `q7` into a WIDTH-bit shift register at the LSB, moving earlier bits toward the MSB.
    - High phase: `cp`=1 for CLK_DIV cycles.
    - The rising edge after the final sample is issued; it is harmless.
    - Bit counter runs 0..WIDTH-1; leave SHIFT at the end of the high phase of bit WIDTH-1.
  - DONE: one cycle.
    - `data` ← shift register; `valid`=1.
    - `changed`=1 iff the shift register ≠ old `data`.
    - `ce_n`=1, `cp`=0.
  - IDLE: SCAN_GAP cycles; `pl_n`=1, `cp`=0, `ce_n`=1. Then LOAD.
- Counter widths: $clog2 of the largest terminal value, computed with saturating care; no wrap inside a phase.
- `cp` and `pl_n` are never low and high-going respectively in the same cycle: `pl_n`=0 only while `cp`=0.
- Reset mid-scan:
  - All outputs return to reset values immediately.
  - The partial word is discarded.
  - After release, the first rising edge enters LOAD.
- The first scan after reset compares against all-ones, so pressed keys report `changed`=1.

## Timing
- Let E0 be the edge on which `pl_n` falls.
- `pl_n` rises at E0+CLK_DIV.
- First `cp` rise at E0+3*CLK_DIV; bit k rises at E0+(3+2k)*CLK_DIV.
- `valid` is high in the cycle following edge E0+(2+2*WIDTH)*CLK_DIV, for exactly one cycle.
- Next `pl_n` fall at E0+(2+2*WIDTH)*CLK_DIV+1+SCAN_GAP.
- Scan period = (2+2*WIDTH)*CLK_DIV+1+SCAN_GAP cycles.
- `data` is stable between `valid` pulses.
- First `pl_n` fall is on the first rising edge after `rst_n` deasserts.

## Test plan
Bench uses WIDTH=16, CLK_DIV=4, SCAN_GAP=20, with a behavioural 165 chain model (load on `pl_n`=0, shift on `cp` rise when `ce_n`=0).

- Pattern 16'hA5C3 loaded → `data`=16'hA5C3 with `valid`=1 exactly 136 cycles after `pl_n` falls; `changed`=1. Next `pl_n` fall 157 cycles after the first.
- Same pattern on the second scan → `valid`=1, `changed`=0, `data` unchanged. Change to 16'hA5C2 on the third scan → `changed`=1.
- All-ones input from reset → first `valid` shows `data`=16'hFFFF with `changed`=0. Counting edges: exactly 16 `cp` rises per scan, `pl_n` low exactly 4 cycles.
- Assert `rst_n`=0 during bit 7 of SHIFT → immediately `pl_n`=1, `cp`=0, `ce_n`=1, `data`=16'hFFFF, `valid`=0. After release, a full 16-bit scan completes correctly with a fresh pattern 16'h0001 → `data`=16'h0001.
- Protocol checker for every scan:
  - `cp` never rises while `pl_n`=0 or `ce_n`=1.
  - `pl_n` never changes while `cp`=1.
  - `valid` is never asserted on two consecutive cycles.
- Toggle a single input bit in the model mid-IDLE → the change appears only after the next LOAD, with `changed`=1 on that scan's `valid`.
